pc_attack_engine: RTL
=====================

// Module: pc_attack_engine
// PURPOSE
//  Opponent (PC) side of the game turn handshake: produces pc_has_move and
//  player_ships_zero, which the game FSM consumes. Armed by the PC_TURN state
//  flag, it picks a pseudo-random cell on the player board and reads it. It
//  marks the cell hit or miss and counts down the remaining player ship cells.
//  It sits between the game FSM and the player-board RAM used by the VGA renderer.
// PARAMETERS
//  BOARD_W      5      board columns
//  BOARD_H      5      board rows
//  THINK_CYCLES 4      idle delay (cycles) after arming, before the first probe; >=1
//  LFSR_SEED    8'hA5  8-bit LFSR reset value; must be nonzero
//  (derived) CELLS=BOARD_W*BOARD_H, AW=$clog2(CELLS), CW=$clog2(CELLS+1)
// PORTS
//  clk               in   1   system clock, rising edge
//  rst               in   1   reset, asynchronous, active-low
//  setup_State       in   1   FSM in SETUP; loads ship counter
//  pc_turn_State     in   1   FSM in PC_TURN; arms one move
//  ship_cells_total  in   CW  number of player ship cells, sampled during SETUP
//  board_rd_addr     out  AW  linear cell index row*BOARD_W+col
//  board_rd_data     in   2   cell code, valid 1 cycle after addr (sync RAM)
//  board_wr_en       out  1   1-cycle write strobe
//  board_wr_addr     out  AW  write index
//  board_wr_data     out  2   written cell code
//  pc_has_move       out  1   1-cycle pulse: move complete
//  player_ships_zero out  1   level: loaded and remaining ship cells == 0
//  last_hit          out  1   result of the most recent move (1=hit)
// BEHAVIOUR
//  Cell codes: 00 water, 01 ship, 10 miss, 11 hit. Attacked = code[1].
//  Reset values: all outputs 0; state IDLE; remaining=0; loaded=0; LFSR=LFSR_SEED.
//  LFSR: 8-bit Fibonacci, taps 8,6,5,4. Advances every cycle, including outside turns.
//  Ship counter:
//   - While setup_State=1: remaining<=ship_cells_total and loaded<=1.
//   - Decrements by 1 on each hit write. Saturates at 0.
//   - player_ships_zero is registered: loaded && remaining==0.
//  FSM:
//   IDLE   -> THINK on rising edge of pc_turn_State (prev=0, now=1), and only
//             if player_ships_zero=0. Timer<=THINK_CYCLES-1.
//   THINK  -> Timer counts down to 0, then idx<=LFSR[AW-1:0] reduced mod CELLS.
//             The reduction is a single conditional subtract of CELLS.
//             Probes<=0. Go to READ.
//   READ   -> Drive board_rd_addr=idx. Go to CHECK next cycle.
//   CHECK  -> If board_rd_data[1]=1 (already attacked):
//              - idx<=(idx==CELLS-1)?0:idx+1; probes++.
//              - If probes==CELLS-1, go to DONE with no write (board exhausted).
//              - Else go to READ.
//             Otherwise go to WRITE.
//   WRITE  -> board_wr_en=1, wr_addr=idx, wr_data = (data==01)?11:10.
//             last_hit<=(data==01). Go to DONE.
//   DONE   -> pc_has_move=1 for exactly one cycle. Go to WAIT_EXIT.
//   WAIT_EXIT -> Return to IDLE when pc_turn_State=0. Guarantees one move per turn.
//  Latency: arm-edge to pc_has_move = THINK_CYCLES + 3 + 2*k cycles,
//   where k = number of attacked cells skipped. Bounded by linear scan.
//  pc_turn_State dropping mid-move (FSM left early): abort to IDLE.
//   A write already issued stands; no pc_has_move is issued.
//  setup_State=1 in any non-IDLE state: force IDLE; counter reloads.
//  Only one board_wr_en pulse per move. No read-modify-write across turns.
// TESTING
//  1. Reset, SETUP with total=3, arm PC_TURN; RAM idx from LFSR holds 01 ->
//     one write of 11 at that idx, last_hit=1, remaining=2, one pc_has_move pulse
//     at cycle THINK_CYCLES+3.
//  2. Picked cell 10, next cell 00 -> wraps to the following index, writes 10,
//     last_hit=0, remaining unchanged, pulse at THINK_CYCLES+5.
//  3. idx=24 attacked, idx=0 water -> wrap to 0, write 10 at addr 0.
//  4. total=1, hit it -> player_ships_zero=1 the cycle after the write; a later
//     arm edge is ignored (no read, no pulse).
//  5. pc_turn_State held high for 50 cycles -> exactly one pulse and one write;
//     deassert, re-arm -> second move.
//  6. Drop pc_turn_State during THINK, and separately drive rst low during
//     CHECK -> no write, no pulse; outputs return to reset values immediately.

Source files
------------

// File: rtl/pc_attack_engine.sv
// PC attack engine: on each PC turn, picks a pseudo-random player cell,
// scans forward past already-attacked cells, then marks hit/miss and
// tracks how many player ship cells remain.
module pc_attack_engine #(
  parameter int          BOARD_W      = 5,
  parameter int          BOARD_H      = 5,
  parameter int          THINK_CYCLES = 4,
  parameter logic [7:0]  LFSR_SEED    = 8'hA5,
  localparam int         CELLS        = BOARD_W * BOARD_H,
  localparam int         AW           = $clog2(CELLS),
  localparam int         CW           = $clog2(CELLS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          setup_State,
  input  logic          pc_turn_State,
  input  logic [CW-1:0] ship_cells_total,
  output logic [AW-1:0] board_rd_addr,
  input  logic [1:0]    board_rd_data,
  output logic          board_wr_en,
  output logic [AW-1:0] board_wr_addr,
  output logic [1:0]    board_wr_data,
  output logic          pc_has_move,
  output logic          player_ships_zero,
  output logic          last_hit
);

  localparam int          TW   = (THINK_CYCLES > 1) ? $clog2(THINK_CYCLES) : 1;
  localparam logic [AW-1:0] LAST = AW'(CELLS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_THINK, S_READ, S_CHECK, S_WRITE, S_DONE, S_WAIT_EXIT
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [AW-1:0]   probes_q, probes_d;
  logic [1:0]      data_q, data_d;
  logic            last_hit_q, last_hit_d;
  logic [CW-1:0]   remaining_q, remaining_d;
  logic            loaded_q, loaded_d;
  logic            zero_q;
  logic [7:0]      lfsr_q;
  logic            turn_q;

  logic            turn_rise;
  logic [AW-1:0]   raw_idx;
  logic [AW-1:0]   pick_idx;
  logic            wr_en;
  logic            move;

  assign turn_rise = pc_turn_State & ~turn_q;
  assign raw_idx   = lfsr_q[AW-1:0];
  // Single conditional subtract; the raw value never reaches 2*CELLS for these sizes.
  assign pick_idx  = (int'(raw_idx) >= CELLS) ? AW'(int'(raw_idx) - CELLS) : raw_idx;

  // Free-running Fibonacci LFSR (taps 8,6,5,4) and turn-flag edge history.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q <= LFSR_SEED;
      turn_q <= 1'b0;
    end else begin
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      turn_q <= pc_turn_State;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      idx_q       <= '0;
      probes_q    <= '0;
      data_q      <= '0;
      last_hit_q  <= 1'b0;
      remaining_q <= '0;
      loaded_q    <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      idx_q       <= idx_d;
      probes_q    <= probes_d;
      data_q      <= data_d;
      last_hit_q  <= last_hit_d;
      remaining_q <= remaining_d;
      loaded_q    <= loaded_d;
      zero_q      <= loaded_d && (remaining_d == '0);
    end
  end

  // Move sequencer: think delay, probe/scan, single write, one-cycle done pulse.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    idx_d      = idx_q;
    probes_d   = probes_q;
    data_d     = data_q;
    last_hit_d = last_hit_q;
    wr_en      = 1'b0;
    move       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (turn_rise && !zero_q) begin
          state_d = S_THINK;
          timer_d = TW'(THINK_CYCLES - 1);
        end
      end
      S_THINK: begin
        if (timer_q == '0) begin
          idx_d    = pick_idx;
          probes_d = '0;
          state_d  = S_READ;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      S_READ: state_d = S_CHECK;
      S_CHECK: begin
        data_d = board_rd_data;
        if (board_rd_data[1]) begin
          idx_d    = (idx_q == LAST) ? '0 : idx_q + 1'b1;
          probes_d = probes_q + 1'b1;
          state_d  = (probes_q == LAST) ? S_DONE : S_READ;
        end else begin
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        wr_en      = 1'b1;
        last_hit_d = (data_q == 2'b01);
        state_d    = S_DONE;
      end
      S_DONE: begin
        move    = 1'b1;
        state_d = S_WAIT_EXIT;
      end
      S_WAIT_EXIT: if (!pc_turn_State) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // A move in flight is abandoned when the turn ends; a write already strobed stands.
    if (!pc_turn_State &&
        (state_q inside {S_THINK, S_READ, S_CHECK, S_WRITE})) state_d = S_IDLE;
    if (setup_State) state_d = S_IDLE;
  end

  // Remaining ship-cell counter: reload during setup, saturating decrement on hit writes.
  always_comb begin
    remaining_d = remaining_q;
    loaded_d    = loaded_q;
    if (setup_State) begin
      remaining_d = ship_cells_total;
      loaded_d    = 1'b1;
    end else if (wr_en && (data_q == 2'b01) && (remaining_q != '0)) begin
      remaining_d = remaining_q - 1'b1;
    end
  end

  assign board_rd_addr     = idx_q;
  assign board_wr_en       = wr_en;
  assign board_wr_addr     = wr_en ? idx_q : '0;
  assign board_wr_data     = wr_en ? ((data_q == 2'b01) ? 2'b11 : 2'b10) : 2'b00;
  assign pc_has_move       = move;
  assign player_ships_zero = zero_q;
  assign last_hit          = last_hit_q;

endmodule
